// File: rtl/quad_input_filter.sv
// Quadrature pin conditioner: two-flop synchroniser, per-channel glitch filter,
// and Gray-code transition classification with a sticky error and saturating count.
module quad_input_filter #(
    parameter int FILTER_CYCLES = 4,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clr_err,
    input  logic                     enc_a_raw,
    input  logic                     enc_b_raw,
    output logic                     enc_a,
    output logic                     enc_b,
    output logic                     edge_valid,
    output logic                     illegal_err,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    // index 0 = channel A, index 1 = channel B
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    filt;
    logic [CW-1:0] cnt [2];
    logic [1:0]    upd;

    assign enc_a = filt[0];
    assign enc_b = filt[1];

    // A channel updates on the edge where its differing level completes qualification.
    always_comb begin
        upd = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            upd[ch] = enable && (s2[ch] != filt[ch]) && (cnt[ch] == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1          <= 2'b00;
            s2          <= 2'b00;
            filt        <= 2'b00;
            cnt[0]      <= '0;
            cnt[1]      <= '0;
            edge_valid  <= 1'b0;
            illegal_err <= 1'b0;
            err_count   <= '0;
        end else begin
            s1 <= {enc_b_raw, enc_a_raw};
            s2 <= s1;

            for (int ch = 0; ch < 2; ch++) begin
                if (!enable || (s2[ch] == filt[ch])) begin
                    cnt[ch] <= '0;
                end else if (upd[ch]) begin
                    cnt[ch]  <= '0;
                    filt[ch] <= s2[ch];
                end else begin
                    cnt[ch] <= cnt[ch] + CW'(1);
                end
            end

            edge_valid <= upd[0] ^ upd[1];

            // An illegal event on the same edge as a clear leaves a count of one.
            if (upd[0] && upd[1]) begin
                illegal_err <= 1'b1;
                if (clr_err) begin
                    err_count <= ERR_CNT_WIDTH'(1);
                end else if (err_count != '1) begin
                    err_count <= err_count + ERR_CNT_WIDTH'(1);
                end
            end else if (clr_err) begin
                illegal_err <= 1'b0;
                err_count   <= '0;
            end
        end
    end

endmodule
